cdr_loop_filter: RTL and testbench

Bang-bang phase detector and digital loop filter for the clock/data recovery loop. Each cycle it takes one set of early/edge/late data samples, already retimed into the `clk` domain, and forms an early/late vote. It accumulates the votes and issues single-cycle `inc`/`dec` step requests to the phase rotator, which advances or retards its phase-select count. It also guarantees that `inc` and `dec` are never asserted together, holds off after each step so the rotator mux can settle, and reports lock.

---
 rtl/cdr_loop_filter.sv | 122 ++++++++++++
 tb/tb_cdr_loop_filter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter: bang-bang phase detector with vote accumulator, post-step
// hold-off and lock detection, driving single-cycle inc/dec rotator requests.
`default_nettype none

module cdr_loop_filter #(
  parameter int THRESH  = 8,
  parameter int ACC_W   = 6,
  parameter int HOLDOFF = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic             s_early,
  input  logic             s_edge,
  input  logic             s_late,
  output logic             inc,
  output logic             dec,
  output logic             locked,
  output logic [ACC_W-1:0] acc
);

  localparam logic [ACC_W-1:0] C_POS  = ACC_W'(THRESH);
  localparam logic [ACC_W-1:0] C_NEG  = ACC_W'(-THRESH);
  localparam logic [3:0]       C_HOLD = 4'(HOLDOFF);

  typedef enum logic {S_TRACK, S_HOLD} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  state_t           state_q, state_d;
  dir_t             last_q, last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       hold_q, hold_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             locked_q, locked_d;
  logic [ACC_W-1:0] acc_nx;

  // A transition exists only when early and late disagree; the edge sample
  // then sides with one of them and tells which way the clock is off.
  logic vote_up, vote_dn, trans;
  assign trans   = sample_valid & (s_early ^ s_late);
  assign vote_up = trans & ~(s_edge ^ s_late);
  assign vote_dn = trans & ~(s_edge ^ s_early);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_TRACK;
      last_q   <= DIR_NONE;
      acc_q    <= '0;
      hold_q   <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      acc_q    <= acc_d;
      hold_q   <= hold_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    acc_d    = acc_q;
    hold_d   = hold_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    locked_d = locked_q;
    acc_nx   = vote_up ? acc_q + ACC_W'(1) : acc_q - ACC_W'(1);

    case (state_q)
      S_TRACK: begin
        if (vote_up || vote_dn) begin
          if (acc_nx == C_POS || acc_nx == C_NEG) begin
            acc_d = '0;
            if (C_HOLD != 4'd0) begin
              state_d = S_HOLD;
              hold_d  = C_HOLD;
            end
            if (acc_nx == C_POS) begin
              inc_d  = 1'b1;
              last_d = DIR_UP;
              if (last_q == DIR_DN)      locked_d = 1'b1;
              else if (last_q == DIR_UP) locked_d = 1'b0;
            end else begin
              dec_d  = 1'b1;
              last_d = DIR_DN;
              if (last_q == DIR_UP)      locked_d = 1'b1;
              else if (last_q == DIR_DN) locked_d = 1'b0;
            end
          end else begin
            acc_d = acc_nx;
          end
        end
      end
      S_HOLD: begin
        acc_d  = '0;
        hold_d = hold_q - 4'd1;
        if (hold_q <= 4'd1) begin
          state_d = S_TRACK;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = S_TRACK;
        hold_d  = '0;
      end
    endcase
  end

  assign inc    = inc_q;
  assign dec    = dec_q;
  assign locked = locked_q;
  assign acc    = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_cdr_loop_filter.sv
// tb_cdr_loop_filter: directed vectors with hand-computed expectations fed
// through a scoreboard queue, plus a random phase with invariant checks.
`default_nettype none

module tb_cdr_loop_filter;

  localparam logic [2:0] UP = 3'b011;  // (e,g,l) = (0,1,1): clock late
  localparam logic [2:0] DN = 3'b110;  // (e,g,l) = (1,1,0): clock early

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic       s_early, s_edge, s_late;
  logic       inc, dec, locked;
  logic [5:0] acc;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int   tag;
    logic chk;
    logic inc;
    logic dec;
    logic locked;
    int   acc;
  } exp_t;

  exp_t q[$];

  cdr_loop_filter #(.THRESH(8), .ACC_W(6), .HOLDOFF(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .s_early      (s_early),
    .s_edge       (s_edge),
    .s_late       (s_late),
    .inc          (inc),
    .dec          (dec),
    .locked       (locked),
    .acc          (acc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic r, input logic v, input logic [2:0] s, input logic chk,
                     input logic ei, input logic ed, input logic el, input int ea, input int tag);
    exp_t e;
    @(negedge clk);
    rst          = r;
    sample_valid = v;
    {s_early, s_edge, s_late} = s;
    e.tag = tag; e.chk = chk; e.inc = ei; e.dec = ed; e.locked = el; e.acc = ea;
    q.push_back(e);
  endtask

  // Monitor: one expected entry per driven cycle, checked just after the edge.
  int cycle = 0;
  int last_step = -1000;
  initial begin
    exp_t e;
    int   got;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (q.size() != 0) begin
        e   = q.pop_front();
        got = int'($signed(acc));
        if (e.chk) begin
          n_tests++;
          if ($isunknown({inc, dec, locked, acc}) || inc !== e.inc || dec !== e.dec ||
              locked !== e.locked || got != e.acc) begin
            n_fail++;
            $display("FAIL vec%0d cycle=%0d: got inc=%b dec=%b locked=%b acc=%0d, required inc=%b dec=%b locked=%b acc=%0d",
                     e.tag, cycle, inc, dec, locked, got, e.inc, e.dec, e.locked, e.acc);
          end
        end
        n_tests++;
        if (inc === 1'b1 && dec === 1'b1) begin
          n_fail++;
          $display("FAIL exclusive cycle=%0d: got inc=1 dec=1, required not both", cycle);
        end
        n_tests++;
        if (got < -7 || got > 7) begin
          n_fail++;
          $display("FAIL acc_range cycle=%0d: got acc=%0d, required -7..7", cycle, got);
        end
        if (rst === 1'b0) begin
          last_step = -1000;
        end else if (inc === 1'b1 || dec === 1'b1) begin
          n_tests++;
          if (cycle - last_step < 12) begin
            n_fail++;
            $display("FAIL spacing cycle=%0d: got %0d cycles between steps, required >= 12",
                     cycle, cycle - last_step);
          end
          last_step = cycle;
        end
      end
    end
  end

  initial begin
    int ea;
    logic ei;
    rst = 1'b0; sample_valid = 1'b0; s_early = 1'b0; s_edge = 1'b0; s_late = 1'b0;

    // Reset held with random samples
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'($urandom), 3'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 0, 100 + i);

    // Up stepping: steps on samples 8, 20, 32, four ignored samples after each
    for (int i = 1; i <= 32; i++) begin
      ei = 1'b0;
      if (i <= 8) begin
        ea = i;
      end else begin
        ea = ((i - 9) % 12) < 4 ? 0 : ((i - 9) % 12) - 3;
      end
      if (ea == 8) begin
        ea = 0;
        ei = 1'b1;
      end
      cyc(1'b1, 1'b1, UP, 1'b1, ei, 1'b0, 1'b0, ea, 200 + i);
    end
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, UP, 1'b1, 1'b0, 1'b0, 1'b0, 0, 250 + i);

    // Down step then opposite up step sets lock; same-direction step clears it
    cyc(1'b0, 1'b1, UP, 1'b1, 1'b0, 1'b0, 1'b0, 0, 300);
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 1'b1, DN, 1'b1, 1'b0, i == 8, 1'b0, (i == 8) ? 0 : -i, 310 + i);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, DN, 1'b1, 1'b0, 1'b0, 1'b0, 0, 320 + i);
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 1'b1, UP, 1'b1, i == 8, 1'b0, i == 8, (i == 8) ? 0 : i, 330 + i);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, UP, 1'b1, 1'b0, 1'b0, 1'b1, 0, 340 + i);
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 1'b1, UP, 1'b1, i == 8, 1'b0, i != 8, (i == 8) ? 0 : i, 350 + i);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, UP, 1'b1, 1'b0, 1'b0, 1'b0, 0, 360 + i);

    // Null votes and cancellation
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 400);
    cyc(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 401);
    cyc(1'b1, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 0, 402);
    cyc(1'b1, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 403);
    cyc(1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 404);
    cyc(1'b1, 1'b0, UP,     1'b1, 1'b0, 1'b0, 1'b0, 0, 405);
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, 1'b1, UP, 1'b1, 1'b0, 1'b0, 1'b0, i, 410 + i);
    cyc(1'b1, 1'b0, UP,     1'b1, 1'b0, 1'b0, 1'b0, 5, 420);
    cyc(1'b1, 1'b0, DN,     1'b1, 1'b0, 1'b0, 1'b0, 5, 421);
    cyc(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5, 422);
    cyc(1'b1, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 5, 423);
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, 1'b1, DN, 1'b1, 1'b0, 1'b0, 1'b0, 5 - i, 430 + i);
    cyc(1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1, 440);
    cyc(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 441);

    // Reset in the second HOLD cycle; last direction must be forgotten
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 1'b1, DN, 1'b1, 1'b0, i == 8, 1'b0, (i == 8) ? 0 : -i, 500 + i);
    cyc(1'b1, 1'b1, DN, 1'b1, 1'b0, 1'b0, 1'b0, 0, 510);
    cyc(1'b0, 1'b1, DN, 1'b1, 1'b0, 1'b0, 1'b0, 0, 511);
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 1'b1, UP, 1'b1, i == 8, 1'b0, 1'b0, (i == 8) ? 0 : i, 520 + i);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, UP, 1'b1, 1'b0, 1'b0, 1'b0, 0, 530 + i);

    // Reset with acc = -6, checked before the next clock edge
    for (int i = 1; i <= 6; i++)
      cyc(1'b1, 1'b1, DN, 1'b1, 1'b0, 1'b0, 1'b0, -i, 600 + i);
    cyc(1'b0, 1'b1, DN, 1'b1, 1'b0, 1'b0, 1'b0, 0, 610);
    #1;
    n_tests++;
    if (acc !== 6'd0 || inc !== 1'b0 || dec !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got inc=%b dec=%b locked=%b acc=%0d before clock edge, required all 0",
               inc, dec, locked, int'($signed(acc)));
    end
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 1'b1, DN, 1'b1, 1'b0, i == 8, 1'b0, (i == 8) ? 0 : -i, 620 + i);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, DN, 1'b1, 1'b0, 1'b0, 1'b0, 0, 630 + i);

    // Random samples: invariants only
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 700);
    for (int i = 0; i < 10000; i++)
      cyc(1'b1, 1'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 0, 1000);

    @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
